// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: control-vector layout and NOP encoding shared by the ID/EX stage.
package id_ex_stage_pkg;
    localparam int CTRL_WIDTH     = 12;
    localparam int CTRL_JMP       = 11;
    localparam int CTRL_BRANCH_NE = 10;
    localparam int CTRL_BRANCH_EQ = 9;
    localparam int CTRL_ALU_OP_HI = 8;
    localparam int CTRL_ALU_OP_LO = 6;
    localparam int CTRL_ALU_SRC   = 5;
    localparam int CTRL_REG_DST   = 4;
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_READ  = 2;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_MEM_TO_REG = 0;
    localparam logic [CTRL_WIDTH-1:0] CTRL_NOP = 12'h000;
endpackage

// File: rtl/id_ex_stage_hazard_detect_unit.sv
// hazard_detect_unit: combinational load-use detection and PC / IF/ID stall request.
module hazard_detect_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      id_alu_src,
    input  logic                      id_mem_write,
    input  logic                      id_branch_ne,
    input  logic                      id_branch_eq,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic                      hold,
    output logic                      load_use,
    output logic                      stall
);
    logic use_rt;
    assign use_rt   = ~id_alu_src | id_mem_write | id_branch_ne | id_branch_eq;
    assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                      ((ex_rt == id_rs) | (use_rt & (ex_rt == id_rt)));
    // Held low during reset so upstream stages are never frozen by a stale hold.
    assign stall    = reset & (load_use | hold);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbles, hold and flush handling.
// Optional hazard statistics counters are built when ID_EX_HAZARD_STATS_EN is defined.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int CTRL_WIDTH     = 12,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid_i,
    input  logic [CTRL_WIDTH-1:0]     id_ctrl_i,
    input  logic [DATA_WIDTH-1:0]     id_pc_plus_4_i,
    input  logic [DATA_WIDTH-1:0]     id_read_data_1_i,
    input  logic [DATA_WIDTH-1:0]     id_read_data_2_i,
    input  logic [DATA_WIDTH-1:0]     id_imm_ext_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_shamt_i,
    input  logic [5:0]                id_funct_i,
    input  logic                      flush_i,
    input  logic                      hold_i,
    output logic                      stall_o,
    output logic                      ex_valid_o,
    output logic [CTRL_WIDTH-1:0]     ex_ctrl_o,
    output logic [DATA_WIDTH-1:0]     ex_pc_plus_4_o,
    output logic [DATA_WIDTH-1:0]     ex_read_data_1_o,
    output logic [DATA_WIDTH-1:0]     ex_read_data_2_o,
    output logic [DATA_WIDTH-1:0]     ex_imm_ext_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_shamt_o,
    output logic [5:0]                ex_funct_o,
    output logic [31:0]               bubble_count_o,
    output logic [31:0]               flush_count_o
);
    import id_ex_stage_pkg::*;

    logic load_use, flush_pending, flush_now, take;

    hazard_detect_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard (
        .reset        (reset),
        .id_valid     (id_valid_i),
        .id_alu_src   (id_ctrl_i[CTRL_ALU_SRC]),
        .id_mem_write (id_ctrl_i[CTRL_MEM_WRITE]),
        .id_branch_ne (id_ctrl_i[CTRL_BRANCH_NE]),
        .id_branch_eq (id_ctrl_i[CTRL_BRANCH_EQ]),
        .id_rs        (id_rs_i),
        .id_rt        (id_rt_i),
        .ex_valid     (ex_valid_o),
        .ex_mem_read  (ex_ctrl_o[CTRL_MEM_READ]),
        .ex_rt        (ex_rt_o),
        .hold         (hold_i),
        .load_use     (load_use),
        .stall        (stall_o)
    );

    assign flush_now = flush_i | flush_pending;
    assign take      = ~(flush_now | load_use);

    // A flush seen during hold is remembered and applied on the first free edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_pending    <= 1'b0;
            ex_valid_o       <= 1'b0;
            ex_ctrl_o        <= CTRL_NOP;
            ex_pc_plus_4_o   <= '0;
            ex_read_data_1_o <= '0;
            ex_read_data_2_o <= '0;
            ex_imm_ext_o     <= '0;
            ex_rs_o          <= '0;
            ex_rt_o          <= '0;
            ex_rd_o          <= '0;
            ex_shamt_o       <= '0;
            ex_funct_o       <= '0;
        end else if (hold_i) begin
            flush_pending    <= flush_pending | flush_i;
        end else begin
            flush_pending    <= 1'b0;
            ex_valid_o       <= take & id_valid_i;
            ex_ctrl_o        <= (take && id_valid_i) ? id_ctrl_i : CTRL_NOP;
            ex_pc_plus_4_o   <= take ? id_pc_plus_4_i   : '0;
            ex_read_data_1_o <= take ? id_read_data_1_i : '0;
            ex_read_data_2_o <= take ? id_read_data_2_i : '0;
            ex_imm_ext_o     <= take ? id_imm_ext_i     : '0;
            ex_rs_o          <= take ? id_rs_i          : '0;
            ex_rt_o          <= take ? id_rt_i          : '0;
            ex_rd_o          <= take ? id_rd_i          : '0;
            ex_shamt_o       <= take ? id_shamt_i       : '0;
            ex_funct_o       <= take ? id_funct_i       : '0;
        end
    end

`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] bubble_count, flush_count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (!hold_i) begin
            if (!flush_now && load_use && bubble_count != '1)
                bubble_count <= bubble_count + 32'd1;
            if (flush_now && flush_count != '1)
                flush_count <= flush_count + 32'd1;
        end
    end
    assign bubble_count_o = bubble_count;
    assign flush_count_o  = flush_count;
`else
    assign bubble_count_o = '0;
    assign flush_count_o  = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven scoreboard bench for the ID/EX pipeline register.
module tb_id_ex_stage;
    typedef enum logic [1:0] {CAP, LU, FL, HLD} kind_t;
    typedef struct packed {
        logic        valid;
        logic [11:0] ctrl;
        logic [4:0]  rs, rt;
        logic        flush, hold, stall;
        kind_t       kind;
    } vec_t;
    typedef struct packed {
        logic        valid;
        logic [11:0] ctrl;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
    } ex_t;

    localparam logic [11:0] LW = 12'h00D, ADD = 12'h098, ADDI = 12'h028, SW = 12'h022, BEQ = 12'h240;

    logic clk = 0, reset = 0;
    logic id_valid_i = 0, flush_i = 0, hold_i = 0;
    logic [11:0] id_ctrl_i = '0;
    logic [31:0] id_pc_plus_4_i = '0, id_read_data_1_i = '0, id_read_data_2_i = '0, id_imm_ext_i = '0;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, id_rd_i = '0, id_shamt_i = '0;
    logic [5:0] id_funct_i = '0;
    logic stall_o, ex_valid_o;
    logic [11:0] ex_ctrl_o;
    logic [31:0] ex_pc_plus_4_o, ex_read_data_1_o, ex_read_data_2_o, ex_imm_ext_o;
    logic [4:0] ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o;
    logic [5:0] ex_funct_o;
    logic [31:0] bubble_count_o, flush_count_o;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_pc_plus_4_i(id_pc_plus_4_i), .id_read_data_1_i(id_read_data_1_i),
        .id_read_data_2_i(id_read_data_2_i), .id_imm_ext_i(id_imm_ext_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_shamt_i(id_shamt_i),
        .id_funct_i(id_funct_i), .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .ex_pc_plus_4_o(ex_pc_plus_4_o),
        .ex_read_data_1_o(ex_read_data_1_o), .ex_read_data_2_o(ex_read_data_2_o),
        .ex_imm_ext_o(ex_imm_ext_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .ex_shamt_o(ex_shamt_o), .ex_funct_o(ex_funct_o),
        .bubble_count_o(bubble_count_o), .flush_count_o(flush_count_o)
    );

    ex_t act, cur;
    ex_t q[$];
    int n_chk = 0, n_fail = 0, n_lu = 0, n_fl = 0;
    vec_t tbl[31];

    assign act = {ex_valid_o, ex_ctrl_o, ex_pc_plus_4_o, ex_read_data_1_o, ex_read_data_2_o,
                  ex_imm_ext_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o, ex_funct_o};

    function automatic vec_t mk(input logic v, input logic [11:0] c, input logic [4:0] rs, rt,
                                input logic f, h, s, input kind_t k);
        vec_t r;
        r.valid = v; r.ctrl = c; r.rs = rs; r.rt = rt;
        r.flush = f; r.hold = h; r.stall = s; r.kind = k;
        return r;
    endfunction

    task automatic chk(input string name, input logic [191:0] a, input logic [191:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        ex_t e;
        @(negedge clk);
        id_valid_i = v.valid; id_ctrl_i = v.ctrl; id_rs_i = v.rs; id_rt_i = v.rt;
        id_rd_i = v.rt ^ 5'd3; id_shamt_i = 5'($urandom); id_funct_i = 6'($urandom);
        id_pc_plus_4_i = $urandom; id_read_data_1_i = $urandom;
        id_read_data_2_i = $urandom; id_imm_ext_i = $urandom;
        flush_i = v.flush; hold_i = v.hold;
        #1 chk({name, " stall"}, 192'(stall_o), 192'(v.stall));
        e = '0;
        if (v.kind == CAP) begin
            e.valid = v.valid; e.ctrl = v.valid ? v.ctrl : 12'h000;
            e.pc = id_pc_plus_4_i; e.rd1 = id_read_data_1_i; e.rd2 = id_read_data_2_i;
            e.imm = id_imm_ext_i; e.rs = v.rs; e.rt = v.rt; e.rd = id_rd_i;
            e.shamt = id_shamt_i; e.funct = id_funct_i;
        end else if (v.kind == HLD) e = cur;
        if (v.kind == LU) n_lu++;
        if (v.kind == FL) n_fl++;
        cur = e;
        q.push_back(e);
        @(posedge clk);
        #1 chk({name, " ex"}, 192'(act), 192'(q.pop_front()));
    endtask

    initial begin
        tbl[0]  = mk(1, LW,   1, 8, 0, 0, 0, CAP);
        tbl[1]  = mk(1, ADD,  8, 2, 0, 0, 1, LU);
        tbl[2]  = mk(1, ADD,  8, 2, 0, 0, 0, CAP);
        tbl[3]  = mk(1, LW,   0, 0, 0, 0, 0, CAP);
        tbl[4]  = mk(1, ADD,  0, 0, 0, 0, 0, CAP);
        tbl[5]  = mk(1, LW,   3, 8, 0, 0, 0, CAP);
        tbl[6]  = mk(1, ADDI, 9, 8, 0, 0, 0, CAP);
        tbl[7]  = mk(1, LW,   3, 8, 0, 0, 0, CAP);
        tbl[8]  = mk(1, SW,   9, 8, 0, 0, 1, LU);
        tbl[9]  = mk(1, SW,   9, 8, 0, 0, 0, CAP);
        tbl[10] = mk(0, ADD,  8, 2, 0, 0, 0, CAP);
        tbl[11] = mk(1, LW,   1, 5, 0, 0, 0, CAP);
        tbl[12] = mk(0, ADD,  5, 5, 0, 0, 0, CAP);
        tbl[13] = mk(1, LW,   1, 5, 0, 0, 0, CAP);
        tbl[14] = mk(1, LW,   2, 5, 0, 0, 1, LU);
        tbl[15] = mk(1, LW,   2, 5, 0, 0, 0, CAP);
        tbl[16] = mk(1, BEQ,  1, 5, 0, 0, 1, LU);
        tbl[17] = mk(1, BEQ,  1, 5, 0, 0, 0, CAP);
        tbl[18] = mk(1, ADD,  1, 2, 1, 0, 0, FL);
        tbl[19] = mk(1, ADD,  1, 2, 0, 0, 0, CAP);
        tbl[20] = mk(1, LW,   1, 7, 0, 0, 0, CAP);
        tbl[21] = mk(1, ADD,  7, 2, 0, 1, 1, HLD);
        tbl[22] = mk(1, ADD,  7, 2, 1, 1, 1, HLD);
        tbl[23] = mk(1, ADD,  7, 2, 0, 1, 1, HLD);
        tbl[24] = mk(1, ADD,  7, 2, 0, 0, 1, FL);
        tbl[25] = mk(1, ADD,  7, 2, 0, 0, 0, CAP);
        tbl[26] = mk(1, LW,   1, 4, 0, 0, 0, CAP);
        tbl[27] = mk(1, ADD,  4, 2, 1, 0, 1, FL);
        tbl[28] = mk(1, ADD,  4, 2, 0, 0, 0, CAP);
        tbl[29] = mk(1, ADD,  1, 2, 0, 1, 1, HLD);
        tbl[30] = mk(1, ADD,  1, 2, 0, 0, 0, CAP);

        cur = '0;
        hold_i = 1;
        #1;
        chk("reset ex", 192'(act), 192'(0));
        chk("reset stall", 192'(stall_o), 192'(0));
        chk("reset counters", 192'({bubble_count_o, flush_count_o}), 192'(0));
        @(negedge clk); hold_i = 0;
        @(negedge clk); reset = 1;

        for (int i = 0; i < 31; i++) apply(tbl[i], $sformatf("v%0d", i));

`ifdef ID_EX_HAZARD_STATS_EN
        chk("bubble_count", 192'(bubble_count_o), 192'(n_lu));
        chk("flush_count", 192'(flush_count_o), 192'(n_fl));
`else
        chk("bubble_count", 192'(bubble_count_o), 192'(0));
        chk("flush_count", 192'(flush_count_o), 192'(0));
`endif

        apply(mk(1, 12'h018, 1, 2, 0, 0, 0, CAP), "pre_reset");
        @(negedge clk); hold_i = 1; flush_i = 1;
        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("async reset ex", 192'(act), 192'(0));
        chk("async reset stall", 192'(stall_o), 192'(0));
        chk("async reset counters", 192'({bubble_count_o, flush_count_o}), 192'(0));
        cur = '0;
        q.delete();
        @(negedge clk); reset = 1; hold_i = 0; flush_i = 0;
        apply(mk(1, ADD, 1, 2, 0, 0, 0, CAP), "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
